// File: rtl/tdc_hw_stats.sv
// tdc_hw_stats: batch statistics over Hamming-weight samples from tdc_top.
// Accumulates 2^LOG_NS accepted samples, then latches sum, mean, min, max
// and a saturation count, and offers them on an 8-bit byte mux.
//
// Sample handshake: hw_in is taken on a rising edge when en=1, the FSM is
// in ACC, hw_val=1 and start=0. There is no back-pressure; a sample offered
// while the block is idle, frozen (en=0) or restarting is dropped.
module tdc_hw_stats #(
   parameter int N      = 64,
   parameter int HW_W   = $clog2(N) + 1,
   parameter int LOG_NS = 4,
   parameter int SUM_W  = HW_W + LOG_NS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              start,
   input  logic [HW_W-1:0]   hw_in,
   input  logic              hw_val,
   input  logic [1:0]        sel,
   output logic              busy,
   output logic              done,
   output logic              res_valid,
   output logic [SUM_W-1:0]  sum,
   output logic [HW_W-1:0]   mean,
   output logic [HW_W-1:0]   min_hw,
   output logic [HW_W-1:0]   max_hw,
   output logic [LOG_NS:0]   sat_cnt,
   output logic [7:0]        rd_byte
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ACC  = 1'b1;

   localparam logic [HW_W-1:0]   N_HW     = HW_W'(N);
   // Index of the last sample of a batch (2^LOG_NS-1) is all ones.
   localparam logic [LOG_NS-1:0] CNT_LAST = '1;

   logic [0:0]        state;
   logic [SUM_W-1:0]  w_sum;
   logic [HW_W-1:0]   w_min;
   logic [HW_W-1:0]   w_max;
   logic [LOG_NS:0]   w_sat;
   logic [LOG_NS-1:0] w_cnt;
   logic              done_q;

   logic [HW_W-1:0]   s_clip;
   logic              is_sat;
   logic [SUM_W-1:0]  sum_nxt;
   logic [HW_W-1:0]   min_nxt;
   logic [HW_W-1:0]   max_nxt;
   logic [LOG_NS:0]   sat_nxt;
   logic              last;

   // Working values as they would be after accepting the current sample.
   always_comb begin
      s_clip  = (hw_in > N_HW) ? N_HW : hw_in;
      is_sat  = (hw_in == '0) || (hw_in >= N_HW);
      sum_nxt = w_sum + SUM_W'(s_clip);
      min_nxt = (s_clip < w_min) ? s_clip : w_min;
      max_nxt = (s_clip > w_max) ? s_clip : w_max;
      sat_nxt = w_sat + {{LOG_NS{1'b0}}, is_sat};
      last    = (state == S_ACC) && hw_val && !start && (w_cnt == CNT_LAST);
   end

   // FSM, working accumulators and result latch; en=0 holds everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         w_sum     <= '0;
         w_min     <= '1;
         w_max     <= '0;
         w_sat     <= '0;
         w_cnt     <= '0;
         done_q    <= 1'b0;
         res_valid <= 1'b0;
         sum       <= '0;
         mean      <= '0;
         min_hw    <= '0;
         max_hw    <= '0;
         sat_cnt   <= '0;
      end else if (en) begin
         done_q <= 1'b0;
         if (start) begin
            // Restart wins over any sample offered in the same cycle.
            state <= S_ACC;
            w_sum <= '0;
            w_min <= '1;
            w_max <= '0;
            w_sat <= '0;
            w_cnt <= '0;
         end else if (state == S_ACC && hw_val) begin
            w_sum <= sum_nxt;
            w_min <= min_nxt;
            w_max <= max_nxt;
            w_sat <= sat_nxt;
            w_cnt <= w_cnt + 1'b1;
            if (last) begin
               state     <= S_IDLE;
               done_q    <= 1'b1;
               res_valid <= 1'b1;
               sum       <= sum_nxt;
               mean      <= HW_W'(sum_nxt >> LOG_NS);
               min_hw    <= min_nxt;
               max_hw    <= max_nxt;
               sat_cnt   <= sat_nxt;
            end
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   // busy is the FSM state itself; done is masked while frozen.
   always_comb begin
      busy = (state == S_ACC);
      done = done_q & en;
   end

   // Readout byte mux for the 8-bit pin interface.
   always_comb begin
      rd_byte = 8'h00;
      case (sel)
         2'd0:    rd_byte = 8'(mean);
         2'd1:    rd_byte = 8'(min_hw);
         2'd2:    rd_byte = 8'(max_hw);
         default: rd_byte = {res_valid, busy, 6'(sat_cnt)};
      endcase
   end

endmodule

// File: tb/tb_tdc_hw_stats.sv
// Bench for tdc_hw_stats: directed scenarios plus randomized batches,
// checked each cycle against a queue-based batch model.
module tb_tdc_hw_stats;

   localparam int N      = 64;
   localparam int HW_W   = 7;
   localparam int LOG_NS = 4;
   localparam int SUM_W  = 11;
   localparam int NS     = 16;

   logic              clk = 1'b0;
   logic              rst, en, start, hw_val;
   logic [HW_W-1:0]   hw_in;
   logic [1:0]        sel;
   logic              busy, done, res_valid;
   logic [SUM_W-1:0]  sum;
   logic [HW_W-1:0]   mean, min_hw, max_hw;
   logic [LOG_NS:0]   sat_cnt;
   logic [7:0]        rd_byte;

   tdc_hw_stats #(.N(N), .LOG_NS(LOG_NS)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .hw_in(hw_in),
      .hw_val(hw_val), .sel(sel), .busy(busy), .done(done),
      .res_valid(res_valid), .sum(sum), .mean(mean), .min_hw(min_hw),
      .max_hw(max_hw), .sat_cnt(sat_cnt), .rd_byte(rd_byte)
   );

   // Clock
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   // Reference model: accepted raw samples of the current batch.
   int q[$];
   bit m_busy, m_rv, m_done;
   int m_sum, m_mean, m_min, m_max, m_sat;
   logic [SUM_W-1:0] exp_q[$];
   int done_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic void model_finish();
      int s;
      m_sum = 0; m_min = 1 << 30; m_max = 0; m_sat = 0;
      foreach (q[i]) begin
         s = (q[i] > N) ? N : q[i];
         m_sum += s;
         if (s < m_min) m_min = s;
         if (s > m_max) m_max = s;
         if (q[i] == 0 || q[i] >= N) m_sat++;
      end
      m_mean = m_sum / NS;
   endfunction

   // Driver: apply one cycle of inputs, advance, update model, check outputs.
   task automatic step(input bit r, input bit e, input bit st, input bit v,
                       input int h, input int sl);
      logic [SUM_W-1:0] es;
      int exp_rd;
      rst = r; en = e; start = st; hw_val = v; hw_in = HW_W'(h); sel = 2'(sl);
      @(posedge clk);
      #1;
      m_done = 1'b0;
      if (r) begin
         q.delete();
         m_busy = 0; m_rv = 0;
         m_sum = 0; m_mean = 0; m_min = 0; m_max = 0; m_sat = 0;
      end else if (e) begin
         if (st) begin
            q.delete();
            m_busy = 1;
         end else if (m_busy && v) begin
            q.push_back(h);
            if (q.size() == NS) begin
               model_finish();
               m_rv = 1; m_done = 1; m_busy = 0;
               exp_q.push_back(SUM_W'(m_sum));
            end
         end
      end
      if (done === 1'b1) begin
         done_seen++;
         es = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         chk("done_sum", 32'(sum), 32'(es));
      end
      chk("done", 32'(done), 32'(m_done));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      chk("sum", 32'(sum), m_sum);
      chk("mean", 32'(mean), m_mean);
      chk("min_hw", 32'(min_hw), m_min);
      chk("max_hw", 32'(max_hw), m_max);
      chk("sat_cnt", 32'(sat_cnt), m_sat);
      case (sl)
         0: exp_rd = m_mean;
         1: exp_rd = m_min;
         2: exp_rd = m_max;
         default: exp_rd = (int'(m_rv) << 7) | (int'(m_busy) << 6) | (m_sat & 63);
      endcase
      chk("rd_byte", 32'(rd_byte), exp_rd);
   endtask

   task automatic idle();
      step(0, 1, 0, 0, $urandom_range(0, 127), $urandom_range(0, 3));
   endtask

   task automatic begin_batch();
      step(0, 1, 1, 0, 0, $urandom_range(0, 3));
   endtask

   task automatic sample(input int h, input int gap);
      for (int g = 0; g < gap; g++) idle();
      step(0, 1, 0, 1, h, $urandom_range(0, 3));
   endtask

   task automatic chk_res(input string tag, input int s, input int mn, input int lo,
                          input int hi, input int st);
      chk({tag, "_sum"}, 32'(sum), s);
      chk({tag, "_mean"}, 32'(mean), mn);
      chk({tag, "_min"}, 32'(min_hw), lo);
      chk({tag, "_max"}, 32'(max_hw), hi);
      chk({tag, "_sat"}, 32'(sat_cnt), st);
      chk({tag, "_rv"}, 32'(res_valid), 1);
   endtask

   initial begin
      int ds0;
      int r;
      int guard;
      // Reset
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 3);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sum", 32'(sum), 0);
      chk("rst_min", 32'(min_hw), 0);

      // 16 x 20 back-to-back
      begin_batch();
      for (int i = 0; i < NS; i++) sample(20, 0);
      chk("b20_done", 32'(done), 1);
      chk_res("b20", 320, 20, 20, 20, 0);
      idle();
      chk("b20_done_drop", 32'(done), 0);

      // 0..15 with gaps
      ds0 = done_seen;
      begin_batch();
      for (int i = 0; i < NS; i++) sample(i, $urandom_range(1, 3));
      idle();
      chk_res("ramp", 120, 7, 0, 15, 1);
      chk("ramp_done_cnt", done_seen - ds0, 1);

      // Saturated and clipped
      begin_batch();
      for (int i = 0; i < NS; i++) sample(64, 0);
      chk_res("sat64", 1024, 64, 64, 64, 16);
      begin_batch();
      for (int i = 0; i < NS; i++) sample(70, $urandom_range(0, 1));
      chk_res("clip70", 1024, 64, 64, 64, 16);

      // Abort and restart
      ds0 = done_seen;
      begin_batch();
      for (int i = 0; i < 8; i++) sample(10, 0);
      begin_batch();
      for (int i = 0; i < NS; i++) sample(30, 0);
      idle();
      chk("abort_done_cnt", done_seen - ds0, 1);
      chk_res("abort", 480, 30, 30, 30, 0);

      // Restart in the same cycle as the final sample
      ds0 = done_seen;
      begin_batch();
      for (int i = 0; i < NS - 1; i++) sample(9, 0);
      step(0, 1, 1, 1, 9, 0);
      chk("race_done_cnt", done_seen - ds0, 0);
      for (int i = 0; i < NS; i++) sample(11, 0);
      chk_res("race", 176, 11, 11, 11, 0);

      // Freeze with en=0 mid-batch
      begin_batch();
      for (int i = 0; i < 5; i++) sample(5, 0);
      for (int i = 0; i < 5; i++) step(0, 0, i[0], ~i[0], 99, $urandom_range(0, 3));
      chk("freeze_busy", 32'(busy), 1);
      for (int i = 0; i < 11; i++) sample(5, 0);
      chk_res("freeze", 80, 5, 5, 5, 0);

      // Reset mid-batch
      begin_batch();
      for (int i = 0; i < 10; i++) sample(33, 0);
      step(1, 1, 0, 1, 33, 3);
      chk("rmid_done", 32'(done), 0);
      chk("rmid_busy", 32'(busy), 0);
      chk("rmid_rv", 32'(res_valid), 0);
      chk("rmid_sum", 32'(sum), 0);
      chk("rmid_max", 32'(max_hw), 0);
      chk("rmid_rd", 32'(rd_byte), 0);

      // Completed batch then sel sweep
      begin_batch();
      for (int i = 0; i < NS; i++) sample($urandom_range(0, 127), 0);
      for (int s = 0; s < 4; s++) step(0, 1, 0, 0, 0, s);

      // Randomized batches
      for (int b = 0; b < 8; b++) begin
         begin_batch();
         guard = 0;
         while (m_busy && guard < 300) begin
            r = $urandom_range(0, 99);
            if (r < 5)
               step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 3));
            else if (r < 7)
               step(0, 1, 1, $urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 3));
            else if (r < 35)
               idle();
            else if (r < 45)
               sample((r < 40) ? 0 : $urandom_range(64, 127), 0);
            else
               sample($urandom_range(1, 63), 0);
            guard++;
         end
         idle();
      end

      chk("pending_done", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdc_hw_stats.md
Name: tdc_hw_stats

Overview:
Statistics stage directly downstream of tdc_top. It consumes the per-capture Hamming-weight samples (hw, val_out) and accumulates a fixed-size batch of 2^LOG_NS samples. It then publishes the batch mean, min, max, raw sum and an out-of-range count. A byte-select mux lets the 8-bit TT output pins read the results without widening the pad interface.

Parameters:
N, 64, delay-line taps; a valid hw sample lies in 0..N
HW_W, $clog2(N)+1, hw sample width (7 for N=64)
LOG_NS, 4, log2 of samples per batch (16 by default)
SUM_W, HW_W+LOG_NS, accumulator width; guaranteed not to overflow

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  global enable; when low, the state and all registers hold
start  in  1  one-cycle pulse that begins a new batch
hw_in  in  HW_W  Hamming-weight sample from tdc_top
hw_val  in  1  hw_in is valid this cycle (tdc_top val_out)
sel  in  2  readout byte select
busy  out  1  batch in progress
done  out  1  one-cycle pulse when the batch completes
res_valid  out  1  result registers hold a completed batch
sum  out  SUM_W  latched batch sum
mean  out  HW_W  latched sum>>LOG_NS
min_hw  out  HW_W  latched batch minimum
max_hw  out  HW_W  latched batch maximum
sat_cnt  out  LOG_NS+1  latched count of samples equal to 0 or at/above N
rd_byte  out  8  byte mux for the pins

Behaviour:
- Reset: state IDLE. All outputs, accumulators and the sample counter are 0. The working min register is all-ones.
- en=0 freezes everything:
  - start and hw_val are ignored;
  - done is forced 0.
- FSM states: IDLE, ACC.
  - IDLE + start: clear the working sum, count and sat; set working min = all-ones and working max = 0. Next state ACC, busy=1.
  - Results from a previous batch and res_valid stay as they are until the next completion.
- ACC, hw_val=1: sample accepted in the same cycle.
  - Clip: s = (hw_in > N) ? N : hw_in.
  - sum += s; min = min(min, s); max = max(max, s).
  - sat += 1 if (hw_in == 0) or (hw_in >= N).
  - cnt += 1.
- ACC, hw_val=0: no change.
- Completion: when the sample with cnt == 2^LOG_NS-1 is accepted, the next edge does the following:
  - latches sum/mean/min/max/sat from the updated working values, including that final sample;
  - sets res_valid=1;
  - pulses done=1 for exactly one cycle;
  - clears busy and returns to IDLE.
- Latency: done asserts 1 cycle after the final accepted sample.
- start while in ACC: abort and restart. Working registers are cleared exactly as from IDLE, the state stays ACC, and the hw_val sample in that same cycle is discarded. Latched results are untouched.
- start in the same cycle as the final sample: restart wins. No done pulse, no latch.
- mean uses truncating division (floor). Its maximum is N.
- rd_byte, combinational from latched outputs, zero-extended or truncated to 8 bits:
  - sel=0: mean
  - sel=1: min_hw
  - sel=2: max_hw
  - sel=3: {res_valid, busy, sat_cnt[5:0]}, zero-padded
- Reset mid-batch: returns to the reset state the next cycle, with no done pulse.

Test Plan:
- Reset, then start, then 16 samples of hw=20 back-to-back → done 1 cycle after the 16th sample; sum=320, mean=20, min=20, max=20, sat=0, res_valid=1.
- Samples 0..15 with hw_val gaps of 1-3 cycles → sum=120, mean=7, min=0, max=15, sat=1; busy high throughout; done high for exactly one cycle.
- 16 samples of hw=64 → sum=1024, mean=64, sat=16; the sum does not wrap. Repeat with hw=70 → clipped, same results.
- Start, 8 samples of 10, start again, then 16 samples of 30 → mean=30, min=30; only one done pulse, after the second batch.
- Hold en=0 for 5 cycles mid-batch while toggling hw_val and start → count and state unchanged; the batch then finishes normally with the correct sum.
- Assert rst after 10 samples → all outputs 0, IDLE, no done. Then sweep sel=0..3 after a completed batch → rd_byte matches mean, min, max and the status byte.
